// File: rtl/pwd_pkg.sv
// Shared definitions for the sequential password lock: FSM state encoding
// and the sizing rule for the shared lockout / auto-relock timer.
package pwd_pkg;

   typedef enum logic [1:0] {
      ENTRY    = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2,
      PROG     = 2'd3
   } state_t;

   // One counter serves both timeouts, so it must hold the larger reload value.
   function automatic int timer_width(input int lockout_cyc, input int unlock_cyc);
      int m;
      m = 2;
      if (lockout_cyc > m) m = lockout_cyc;
      if (unlock_cyc > m) m = unlock_cyc;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/pwd_timer.sv
// Loadable down-counter with a registered zero flag; stops at zero until
// reloaded. Load takes priority over counting.
module pwd_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         zero  <= 1'b1;
      end else if (load) begin
         count <= load_val;
         zero  <= (load_val == '0);
      end else if (en && !zero) begin
         count <= count - 1'b1;
         zero  <= (count == W'(1));
      end
   end

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Sequential password lock: compares SEQ_LEN-key attempts against a stored
// password, with failure counting, timed lockout, auto-relock and reprogramming.
module pwd_lock_ctrl
   import pwd_pkg::*;
#(
   parameter int                        KEY_W       = 2,
   parameter int                        SEQ_LEN     = 4,
   parameter logic [KEY_W*SEQ_LEN-1:0]  RST_PWD     = 8'b11_10_01_10,
   parameter int                        MAX_FAIL    = 3,
   parameter int                        LOCKOUT_CYC = 16,
   parameter int                        UNLOCK_CYC  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          key_valid,
   input  logic [KEY_W-1:0]              key,
   input  logic                          relock,
   input  logic                          set_pwd,
   output logic                          unlock,
   output logic                          locked_out,
   output logic                          err,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
   output logic                          prog_busy
);

   localparam int PW  = KEY_W * SEQ_LEN;
   localparam int IW  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int FCW = $clog2(MAX_FAIL + 1);
   localparam int TW  = timer_width(LOCKOUT_CYC, UNLOCK_CYC);

   localparam logic [IW-1:0]  LAST_IDX  = IW'(SEQ_LEN - 1);
   localparam logic [FCW-1:0] FAIL_MAX  = FCW'(MAX_FAIL);
   localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCKOUT_CYC - 1);
   localparam logic [TW-1:0]  UNLK_LOAD = (UNLOCK_CYC > 0) ? TW'(UNLOCK_CYC - 1) : '0;
   localparam logic           AUTO_RELOCK = (UNLOCK_CYC > 0);

   state_t          state;
   logic [IW-1:0]   idx;
   logic            mismatch;
   logic [PW-1:0]   pwd_reg;
   logic [PW-1:0]   shadow;
   logic [PW-1:0]   shadow_nxt;
   logic [KEY_W-1:0] slot;
   logic            miss_now;
   logic            last_key;
   logic [FCW-1:0]  fail_inc;
   logic            lock_trip;
   logic            pass;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_en;
   logic            tmr_zero;

   always_comb begin
      slot       = pwd_reg[idx*KEY_W +: KEY_W];
      miss_now   = mismatch | (key != slot);
      last_key   = (idx == LAST_IDX);
      fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
      shadow_nxt = shadow;
      shadow_nxt[idx*KEY_W +: KEY_W] = key;
      lock_trip  = (state == ENTRY) && key_valid && last_key && miss_now && (fail_inc == FAIL_MAX);
      pass       = (state == ENTRY) && key_valid && last_key && !miss_now;
      tmr_load   = lock_trip || (pass && AUTO_RELOCK);
      tmr_val    = lock_trip ? LOCK_LOAD : UNLK_LOAD;
      tmr_en     = (state == LOCKOUT) || (state == UNLOCKED);
   end

   pwd_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ENTRY;
         idx        <= '0;
         mismatch   <= 1'b0;
         pwd_reg    <= RST_PWD;
         unlock     <= 1'b0;
         locked_out <= 1'b0;
         err        <= 1'b0;
         fail_cnt   <= '0;
         prog_busy  <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ENTRY: begin
               // An attempt always consumes SEQ_LEN keys; the verdict comes on the last one.
               if (key_valid) begin
                  if (last_key) begin
                     idx      <= '0;
                     mismatch <= 1'b0;
                     if (miss_now) begin
                        err      <= 1'b1;
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                           state      <= LOCKOUT;
                           locked_out <= 1'b1;
                        end
                     end else begin
                        state    <= UNLOCKED;
                        unlock   <= 1'b1;
                        fail_cnt <= '0;
                     end
                  end else begin
                     idx      <= idx + 1'b1;
                     mismatch <= miss_now;
                  end
               end
            end
            UNLOCKED: begin
               if (relock || (AUTO_RELOCK && tmr_zero)) begin
                  state  <= ENTRY;
                  unlock <= 1'b0;
               end else if (set_pwd) begin
                  state     <= PROG;
                  prog_busy <= 1'b1;
                  idx       <= '0;
               end
            end
            LOCKOUT: begin
               if (tmr_zero) begin
                  state      <= ENTRY;
                  locked_out <= 1'b0;
                  fail_cnt   <= '0;
               end
            end
            PROG: begin
               if (relock) begin
                  state     <= ENTRY;
                  unlock    <= 1'b0;
                  prog_busy <= 1'b0;
                  idx       <= '0;
               end else if (key_valid) begin
                  if (last_key) begin
                     pwd_reg   <= shadow_nxt;
                     state     <= ENTRY;
                     unlock    <= 1'b0;
                     prog_busy <= 1'b0;
                     idx       <= '0;
                  end else begin
                     shadow <= shadow_nxt;
                     idx    <= idx + 1'b1;
                  end
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Scoreboard bench for pwd_lock_ctrl: default instance plus an auto-relock
// instance (UNLOCK_CYC=8). Each step queues stimulus with its expected outputs.
module tb_pwd_lock_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       d_rst, d_kv, d_rl, d_sp;
   logic [1:0] d_key;
   logic       d_unlock, d_lo, d_err, d_pb;
   logic [1:0] d_fc;

   logic       a_rst, a_kv, a_rl, a_sp;
   logic [1:0] a_key;
   logic       a_unlock, a_lo, a_err, a_pb;
   logic [1:0] a_fc;

   pwd_lock_ctrl dut (
      .clk(clk), .rst(d_rst), .key_valid(d_kv), .key(d_key), .relock(d_rl),
      .set_pwd(d_sp), .unlock(d_unlock), .locked_out(d_lo), .err(d_err),
      .fail_cnt(d_fc), .prog_busy(d_pb)
   );

   pwd_lock_ctrl #(.UNLOCK_CYC(8)) dut_a (
      .clk(clk), .rst(a_rst), .key_valid(a_kv), .key(a_key), .relock(a_rl),
      .set_pwd(a_sp), .unlock(a_unlock), .locked_out(a_lo), .err(a_err),
      .fail_cnt(a_fc), .prog_busy(a_pb)
   );

   typedef struct {
      string      name;
      bit         a;
      logic       rst, kv, rl, sp;
      logic [1:0] k;
      logic [5:0] exp;
   } step_t;

   step_t sb[$];
   int n_chk = 0;
   int n_pass = 0;

   localparam logic [7:0] PW_DEF  = 8'b11_10_01_10;  // 10,01,10,11
   localparam logic [7:0] PW_NEW  = 8'b11_00_11_00;  // 00,11,00,11
   localparam logic [7:0] BAD_A   = 8'b10_10_01_10;  // 10,01,10,10
   localparam logic [7:0] BAD_B   = 8'b11_10_01_00;  // 00,01,10,11
   localparam logic [7:0] BAD_C   = 8'b11_10_10_10;  // 10,10,10,11
   localparam logic [5:0] E0      = 6'b0;

   // {unlock, locked_out, err, fail_cnt[1:0], prog_busy}
   function automatic logic [5:0] E(input logic u, input logic lo, input logic er,
                                    input logic [1:0] fc, input logic pb);
      return {u, lo, er, fc, pb};
   endfunction

   function automatic logic [5:0] d_obs();
      return {d_unlock, d_lo, d_err, d_fc, d_pb};
   endfunction

   function automatic logic [5:0] a_obs();
      return {a_unlock, a_lo, a_err, a_fc, a_pb};
   endfunction

   function automatic void push(input string n, input bit a, input logic r, input logic kv,
                                input logic rl, input logic sp, input logic [1:0] k,
                                input logic [5:0] e);
      step_t s;
      s.name = n; s.a = a; s.rst = r; s.kv = kv; s.rl = rl; s.sp = sp; s.k = k; s.exp = e;
      sb.push_back(s);
   endfunction

   function automatic void push_seq(input string n, input bit a, input logic [7:0] seq,
                                    input logic [5:0] e_mid, input logic [5:0] e_last);
      for (int i = 0; i < 4; i++)
         push(n, a, 1'b0, 1'b1, 1'b0, 1'b0, seq[2*i +: 2], (i == 3) ? e_last : e_mid);
   endfunction

   task automatic drive(input step_t s);
      if (s.a) begin
         a_rst = s.rst; a_kv = s.kv; a_rl = s.rl; a_sp = s.sp; a_key = s.k;
      end else begin
         d_rst = s.rst; d_kv = s.kv; d_rl = s.rl; d_sp = s.sp; d_key = s.k;
      end
      @(negedge clk);
      {d_rst, d_kv, d_rl, d_sp, d_key} = '0;
      {a_rst, a_kv, a_rl, a_sp, a_key} = '0;
   endtask

   task automatic test_reset();
      step_t s;
      logic [5:0] obs;
      push("reset_d", 0, 1, 0, 0, 0, 2'd0, E0);
      push("reset_d_hold", 0, 1, 1, 1, 1, 2'd3, E0);
      push("reset_d_idle", 0, 0, 0, 0, 0, 2'd0, E0);
      push("reset_a", 1, 1, 0, 0, 0, 2'd0, E0);
      push("reset_a_idle", 1, 0, 0, 0, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = s.a ? a_obs() : d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_correct();
      step_t s;
      logic [5:0] obs;
      push_seq("correct", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("correct_hold", 0, 0, 0, 0, 0, 2'd0, E(1, 0, 0, 2'd0, 0));
      push("correct_relock", 0, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_wrong_then_right();
      step_t s;
      logic [5:0] obs;
      push_seq("wrong", 0, BAD_A, E0, E(0, 0, 1, 2'd1, 0));
      push("wrong_err_clear", 0, 0, 0, 0, 0, 2'd0, E(0, 0, 0, 2'd1, 0));
      push_seq("right", 0, PW_DEF, E(0, 0, 0, 2'd1, 0), E(1, 0, 0, 2'd0, 0));
      push("right_relock", 0, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_lockout();
      step_t s;
      logic [5:0] obs;
      int lo_cnt;
      bit done;
      push_seq("fail1", 0, BAD_A, E0, E(0, 0, 1, 2'd1, 0));
      push_seq("fail2", 0, BAD_B, E(0, 0, 0, 2'd1, 0), E(0, 0, 1, 2'd2, 0));
      push_seq("fail3", 0, BAD_C, E(0, 0, 0, 2'd2, 0), E(0, 1, 1, 2'd3, 0));
      push_seq("key_in_lockout", 0, PW_DEF, E(0, 1, 0, 2'd3, 0), E(0, 1, 0, 2'd3, 0));
      push("relock_in_lockout", 0, 0, 0, 1, 1, 2'd0, E(0, 1, 0, 2'd3, 0));
      lo_cnt = 0;
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (d_lo === 1'b1) lo_cnt++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
      done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (d_lo === 1'b1) lo_cnt++;
         else begin done = 1; break; end
      end
      n_chk++;
      if (!done || lo_cnt != 16) $display("FAIL lockout_len: got %0d cycles (ended=%0d) want 16", lo_cnt, done);
      else n_pass++;
      n_chk++;
      if (d_obs() !== E0) $display("FAIL after_lockout: got %b want %b", d_obs(), E0);
      else n_pass++;
      push_seq("unlock_after_lockout", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("relock_after_lockout", 0, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_reprogram();
      step_t s;
      logic [5:0] obs;
      push_seq("unlock_for_prog", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("set_pwd", 0, 0, 0, 0, 1, 2'd0, E(1, 0, 0, 2'd0, 1));
      push_seq("prog_keys", 0, PW_NEW, E(1, 0, 0, 2'd0, 1), E0);
      push_seq("old_pwd_fails", 0, PW_DEF, E0, E(0, 0, 1, 2'd1, 0));
      push_seq("new_pwd_unlocks", 0, PW_NEW, E(0, 0, 0, 2'd1, 0), E(1, 0, 0, 2'd0, 0));
      push("new_relock", 0, 0, 0, 1, 0, 2'd0, E0);
      push("rst_restore", 0, 1, 0, 0, 0, 2'd0, E0);
      push_seq("rst_pwd_unlocks", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("set_pwd2", 0, 0, 0, 0, 1, 2'd0, E(1, 0, 0, 2'd0, 1));
      push("prog_partial", 0, 0, 1, 0, 0, 2'd1, E(1, 0, 0, 2'd0, 1));
      push("prog_abort", 0, 0, 0, 1, 0, 2'd0, E0);
      push_seq("pwd_kept", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("kept_relock", 0, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_gated();
      step_t s;
      logic [5:0] obs;
      push_seq("unlock_for_both", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("relock_and_set", 0, 0, 0, 1, 1, 2'd0, E0);
      push("no_strobe_0", 0, 0, 0, 0, 0, 2'd0, E0);
      push("no_strobe_3", 0, 0, 0, 0, 0, 2'd3, E0);
      push("no_strobe_1", 0, 0, 0, 0, 0, 2'd1, E0);
      push("set_in_entry", 0, 0, 0, 0, 1, 2'd2, E0);
      push_seq("aligned_entry", 0, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("key_in_unlocked", 0, 0, 1, 0, 0, 2'd0, E(1, 0, 0, 2'd0, 0));
      push("key_in_unlocked2", 0, 0, 1, 0, 0, 2'd3, E(1, 0, 0, 2'd0, 0));
      push("gated_relock", 0, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = d_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   task automatic test_auto_relock();
      step_t s;
      logic [5:0] obs;
      int u_cnt;
      bit done;
      push_seq("auto_unlock", 1, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = a_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
      u_cnt = (a_unlock === 1'b1) ? 1 : 0;
      done = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (a_unlock === 1'b1) u_cnt++;
         else begin done = 1; break; end
      end
      n_chk++;
      if (!done || u_cnt != 8) $display("FAIL auto_relock_len: got %0d cycles (ended=%0d) want 8", u_cnt, done);
      else n_pass++;
      n_chk++;
      if (a_obs() !== E0) $display("FAIL after_auto_relock: got %b want %b", a_obs(), E0);
      else n_pass++;
      push("mid_key1", 1, 0, 1, 0, 0, 2'd2, E0);
      push("mid_rst_key2", 1, 1, 1, 0, 0, 2'd1, E0);
      push_seq("post_rst_entry", 1, PW_DEF, E0, E(1, 0, 0, 2'd0, 0));
      push("auto_set_pwd", 1, 0, 0, 0, 1, 2'd0, E(1, 0, 0, 2'd0, 1));
      for (int i = 0; i < 10; i++)
         push("prog_frozen", 1, 0, 0, 0, 0, 2'd0, E(1, 0, 0, 2'd0, 1));
      push("prog_relock", 1, 0, 0, 1, 0, 2'd0, E0);
      while (sb.size() > 0) begin
         s = sb.pop_front(); drive(s); obs = a_obs(); n_chk++;
         if (obs !== s.exp) $display("FAIL %s: got %b want %b", s.name, obs, s.exp);
         else n_pass++;
      end
   endtask

   initial begin
      {d_rst, d_kv, d_rl, d_sp, d_key} = '0;
      {a_rst, a_kv, a_rl, a_sp, a_key} = '0;
      @(negedge clk);
      test_reset();
      test_correct();
      test_wrong_then_right();
      test_lockout();
      test_reprogram();
      test_gated();
      test_auto_relock();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pwd_lock_ctrl.md
Name: pwd_lock_ctrl

Overview:
- Parametrised sequential password lock, the successor to the fixed 2-bit/4-key pwd_unlock.
- Accepts a stream of KEY_W-bit keys, qualified by key_valid, and compares each sequence of SEQ_LEN keys against a stored password register.
- Adds failed-attempt counting, a timed lockout, an optional auto-relock timeout, and in-field password reprogramming while unlocked.
- Sits between the keypad/debounce front end and the access-control logic.

Parameters:
- KEY_W, 2, width of one key symbol.
- SEQ_LEN, 4, keys per password attempt.
- RST_PWD, 8'b11_10_01_10, reset password, width KEY_W*SEQ_LEN. Key i occupies bits [i*KEY_W +: KEY_W] and key 0 is entered first, so the default sequence is 10, 01, 10, 11.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in clk cycles (>=1).
- UNLOCK_CYC, 0, auto-relock timeout in cycles; 0 means stay unlocked until relock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  key strobe; key is sampled on a clk edge where key_valid=1.
- key  in  KEY_W  key symbol.
- relock  in  1  single-cycle request to return to locked.
- set_pwd  in  1  single-cycle request to enter programming; honoured only while unlocked.
- unlock  out  1  high while in UNLOCKED or PROG.
- locked_out  out  1  high while in LOCKOUT.
- err  out  1  one-cycle pulse on each failed attempt.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.
- prog_busy  out  1  high while in PROG.

Behaviour:
- All outputs are registered. On rst: state=ENTRY, idx=0, mismatch=0, pwd_reg=RST_PWD, unlock=0, locked_out=0, err=0, fail_cnt=0, prog_busy=0, timer=0. Reset mid-PROG discards the partial password and restores RST_PWD.
- States: ENTRY, UNLOCKED, LOCKOUT, PROG.
- ENTRY:
  - Each accepted key compares key against pwd_reg slot idx; any miss sets the sticky mismatch flag, then idx increments.
  - An attempt never aborts early; all SEQ_LEN keys are always consumed.
  - On the edge sampling key number SEQ_LEN (idx=SEQ_LEN-1), evaluate the attempt and clear idx and mismatch.
  - Pass: next state UNLOCKED; unlock=1 in the first cycle after that edge; fail_cnt=0.
  - Fail: err pulses in the cycle after the edge and fail_cnt increments. If the new value equals MAX_FAIL, go to LOCKOUT and load timer=LOCKOUT_CYC-1; otherwise stay in ENTRY.
  - relock and set_pwd are ignored in ENTRY.
- UNLOCKED:
  - key_valid is ignored.
  - relock: go to ENTRY next cycle.
  - set_pwd with relock low: go to PROG, idx=0.
  - relock and set_pwd in the same cycle: relock wins.
  - If UNLOCK_CYC>0, timer loads UNLOCK_CYC-1 on entry and counts down each cycle. At 0, go to ENTRY, so unlock stays high for exactly UNLOCK_CYC cycles.
- LOCKOUT:
  - key_valid, relock and set_pwd are all ignored.
  - timer decrements each cycle. When timer=0, go to ENTRY and clear fail_cnt, so locked_out is high for exactly LOCKOUT_CYC cycles.
- PROG:
  - Each accepted key is written to shadow slot idx, then idx increments.
  - After key number SEQ_LEN, pwd_reg<=shadow (atomic update) and go to ENTRY. The device is locked under the new password.
  - relock in PROG aborts: pwd_reg is unchanged and the state goes to ENTRY.
  - The auto-relock timer is frozen while in PROG.
- Widths:
  - idx is $clog2(SEQ_LEN) bits and wraps only through explicit clear.
  - fail_cnt saturates at MAX_FAIL.
  - timer is $clog2(max(LOCKOUT_CYC, UNLOCK_CYC, 2)) bits.

Decomposition:
- Shared package pwd_pkg holds the state encodings (ENTRY=2'd0, UNLOCKED=2'd1, LOCKOUT=2'd2, PROG=2'd3) and a helper function that computes the timer width.
- One sub-module, pwd_timer: loadable down-counter with load, load_val, en, and a registered zero flag. It is shared between the lockout and auto-relock timing.
- The FSM, key comparison and password register stay in pwd_lock_ctrl.

Test Plan:
- Correct entry. rst, then keys 10, 01, 10, 11 on consecutive strobes. Required: unlock=1 in the first cycle after the 4th key edge; err=0; fail_cnt=0.
- Wrong then right. Sequence 10, 01, 10, 10. Required: err pulses for 1 cycle, fail_cnt=1, unlock=0. Then the correct sequence: unlock=1 and fail_cnt=0.
- Lockout. Three wrong sequences. Required: locked_out=1 for exactly 16 cycles; the correct sequence entered during lockout is ignored (unlock=0). After lockout, fail_cnt=0 and the correct sequence unlocks.
- Reprogram. Unlock, pulse set_pwd, enter 00, 11, 00, 11. Required: prog_busy high for the 4 keys, then unlock=0. The old sequence then fails; 00, 11, 00, 11 unlocks. rst restores 10, 01, 10, 11.
- Simultaneous and gated events. relock and set_pwd in the same cycle while unlocked: required state ENTRY with prog_busy=0. key_valid=0 with key toggling: idx does not advance.
- Auto-relock, built with UNLOCK_CYC=8. Unlock, then no relock: unlock high for exactly 8 cycles, then 0. A separate run asserts rst at the 2nd key: idx=0, and a full correct sequence afterwards unlocks.
